clock_ctrl: RTL and testbench

Timekeeping and setting controller for the digital clock. It consumes the divider's 1 Hz, 2 Hz and 1 kHz square waves as level inputs synchronous to `clk` and converts each into a single-cycle tick. From those ticks it runs the hour/minute/second counters, debounces the two user keys, and sequences the RUN/SET mode FSM. It also produces the blink enables and the display digit-scan index consumed by the seven-segment driver.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/clock_ctrl_key_debounce.sv | 62 ++++++
 rtl/clock_ctrl.sv | 156 +++++++++++++++
 tb/tb_clock_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encoding, time limits and wrap helper for clock_ctrl
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam logic [4:0] MAX_HOUR   = 5'd23;
  localparam logic [5:0] MAX_MIN    = 6'd59;
  localparam logic [5:0] MAX_SEC    = 6'd59;
  localparam int         NUM_DIGITS = 6;

  // Increment with wrap to zero once the value reaches its maximum
  function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
    return (value == max) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/clock_ctrl_key_debounce.sv
// rtl/clock_ctrl_key_debounce.sv - key synchronizer, debouncer and press pulse
module key_debounce
  import clock_pkg::*;
#(
  parameter int DEB_TICKS = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sample_en,
  input  logic i_key_raw,
  output logic o_press
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous raw key
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive differing samples; flip the stable level once DEB_TICKS is reached
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (i_sample_en) begin
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_TICKS - 1)) begin
        r_cnt    <= '0;
        r_stable <= ~r_stable;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Delayed stable level for rising-edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
    end
  end

  // Release is deliberately not reported; only the press edge matters
  assign o_press = r_stable & ~r_stable_d;

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - timekeeping, key handling, RUN/SET mode FSM, blink and digit scan
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_TICKS = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clk_1hz,
  input  logic       i_clk_2hz,
  input  logic       i_clk_1khz,
  input  logic       i_key_mode,
  input  logic       i_key_inc,
  output logic [4:0] o_hour,
  output logic [5:0] o_minute,
  output logic [5:0] o_second,
  output logic [1:0] o_mode,
  output logic       o_blink_hour,
  output logic       o_blink_min,
  output logic [2:0] o_scan_sel
);

  localparam logic [2:0] SCAN_LAST = 3'(NUM_DIGITS - 1);

  logic       r_prev_1hz;
  logic       r_prev_2hz;
  logic       r_prev_1khz;
  logic       w_tick_1hz;
  logic       w_tick_2hz;
  logic       w_tick_1k;
  logic       w_press_mode;
  logic       w_press_inc;
  logic       w_mode_change;
  mode_e      r_mode;
  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic       r_blink_phase;
  logic [2:0] r_scan;

  // Previous-value registers for the divider level inputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_1hz  <= 1'b0;
      r_prev_2hz  <= 1'b0;
      r_prev_1khz <= 1'b0;
    end else begin
      r_prev_1hz  <= i_clk_1hz;
      r_prev_2hz  <= i_clk_2hz;
      r_prev_1khz <= i_clk_1khz;
    end
  end

  assign w_tick_1hz = i_clk_1hz  & ~r_prev_1hz;
  assign w_tick_2hz = i_clk_2hz  & ~r_prev_2hz;
  assign w_tick_1k  = i_clk_1khz & ~r_prev_1khz;

  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_mode (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_sample_en (w_tick_1k),
    .i_key_raw   (i_key_mode),
    .o_press     (w_press_mode)
  );

  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_inc (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_sample_en (w_tick_1k),
    .i_key_raw   (i_key_inc),
    .o_press     (w_press_inc)
  );

  // Flag any state change so the blink phase restarts from the visible half
  always_comb begin
    w_mode_change = 1'b0;
    case (r_mode)
      MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN: w_mode_change = w_press_mode;
      default:                               w_mode_change = 1'b1;
    endcase
  end

  // Mode FSM with time counters; the current state decides how ticks and keys are applied
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= MODE_RUN;
      r_hour <= '0;
      r_min  <= '0;
      r_sec  <= '0;
    end else begin
      case (r_mode)
        MODE_RUN: begin
          if (w_tick_1hz) begin
            r_sec <= wrap_inc(r_sec, MAX_SEC);
            if (r_sec == MAX_SEC) begin
              r_min <= wrap_inc(r_min, MAX_MIN);
              if (r_min == MAX_MIN) begin
                r_hour <= 5'(wrap_inc({1'b0, r_hour}, {1'b0, MAX_HOUR}));
              end
            end
          end
          if (w_press_mode) begin
            r_mode <= MODE_SET_HOUR;
          end
        end
        MODE_SET_HOUR: begin
          if (w_press_mode) begin
            r_mode <= MODE_SET_MIN;
          end else if (w_press_inc) begin
            r_hour <= 5'(wrap_inc({1'b0, r_hour}, {1'b0, MAX_HOUR}));
          end
        end
        MODE_SET_MIN: begin
          if (w_press_mode) begin
            r_mode <= MODE_RUN;
            r_sec  <= '0;
          end else if (w_press_inc) begin
            r_min <= wrap_inc(r_min, MAX_MIN);
          end
        end
        default: begin
          r_mode <= MODE_RUN;
        end
      endcase
    end
  end

  // Blink phase toggles at 2 Hz and restarts on every mode change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_phase <= 1'b0;
    end else if (w_mode_change) begin
      r_blink_phase <= 1'b0;
    end else if (w_tick_2hz) begin
      r_blink_phase <= ~r_blink_phase;
    end
  end

  // Digit scan index advances once per 1 kHz tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan <= '0;
    end else if (w_tick_1k) begin
      r_scan <= (r_scan == SCAN_LAST) ? 3'd0 : r_scan + 3'd1;
    end
  end

  assign o_hour       = r_hour;
  assign o_minute     = r_min;
  assign o_second     = r_sec;
  assign o_mode       = r_mode;
  assign o_blink_hour = (r_mode == MODE_SET_HOUR) & r_blink_phase;
  assign o_blink_min  = (r_mode == MODE_SET_MIN)  & r_blink_phase;
  assign o_scan_sel   = r_scan;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - directed self-checking bench for clock_ctrl
module tb_clock_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_1hz = 1'b0;
  logic       clk_2hz = 1'b0;
  logic       clk_1khz = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc = 1'b0;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic       blink_hour;
  logic       blink_min;
  logic [2:0] scan_sel;

  int n_total = 0;
  int n_bad   = 0;

  clock_ctrl #(.DEB_TICKS(DEB)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clk_1hz    (clk_1hz),
    .i_clk_2hz    (clk_2hz),
    .i_clk_1khz   (clk_1khz),
    .i_key_mode   (key_mode),
    .i_key_inc    (key_inc),
    .o_hour       (hour),
    .o_minute     (minute),
    .o_second     (second),
    .o_mode       (mode),
    .o_blink_hour (blink_hour),
    .o_blink_min  (blink_min),
    .o_scan_sel   (scan_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
  endtask

  task automatic hz1_pulse();
    @(negedge clk) clk_1hz = 1'b1;
    @(negedge clk) clk_1hz = 1'b0;
  endtask

  task automatic hz2_pulse();
    @(negedge clk) clk_2hz = 1'b1;
    @(negedge clk) clk_2hz = 1'b0;
  endtask

  task automatic khz_pulse();
    @(negedge clk) clk_1khz = 1'b1;
    @(negedge clk) clk_1khz = 1'b0;
  endtask

  // Clean press and release of the selected keys, each held DEB kHz samples
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    key_mode = m;
    key_inc  = i;
    wait_neg(3);
    repeat (DEB) khz_pulse();
    wait_neg(2);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    wait_neg(3);
    repeat (DEB) khz_pulse();
    wait_neg(2);
  endtask

  initial begin
    do_reset();
    chk("rst_hour", hour, 0);
    chk("rst_min", minute, 0);
    chk("rst_sec", second, 0);
    chk("rst_mode", mode, 0);
    chk("rst_blink_h", blink_hour, 0);
    chk("rst_blink_m", blink_min, 0);
    chk("rst_scan", scan_sel, 0);

    // 1 Hz counting with latency check on the first pulse
    @(negedge clk) clk_1hz = 1'b1;
    #1 chk("lat_before", second, 0);
    @(posedge clk) #1 chk("lat_after", second, 1);
    @(negedge clk) clk_1hz = 1'b0;
    for (int k = 2; k <= 60; k++) begin
      hz1_pulse();
      chk("sec_count", second, k % 60);
    end
    chk("sec_carry_min", minute, 1);
    chk("sec_carry_hour", hour, 0);

    // Scan index
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      khz_pulse();
      chk("scan", scan_sel, k % 6);
    end

    // Mode sequence, freeze, blink and setting wrap
    do_reset();
    repeat (5) hz1_pulse();
    chk("run_sec5", second, 5);
    press(1'b1, 1'b0);
    chk("mode_set_hour", mode, 1);
    chk("blink_h_start", blink_hour, 0);
    hz1_pulse();
    hz1_pulse();
    chk("frozen_sec", second, 5);
    chk("frozen_min", minute, 0);
    hz2_pulse();
    chk("blink_h_on", blink_hour, 1);
    chk("blink_m_off", blink_min, 0);
    hz2_pulse();
    chk("blink_h_off", blink_hour, 0);
    hz2_pulse();
    chk("blink_h_on2", blink_hour, 1);
    repeat (23) press(1'b0, 1'b1);
    chk("hour_23", hour, 23);
    press(1'b0, 1'b1);
    chk("hour_wrap", hour, 0);
    chk("hour_wrap_min", minute, 0);
    repeat (23) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    chk("mode_set_min", mode, 2);
    chk("blink_m_clear", blink_min, 0);
    chk("blink_h_leave", blink_hour, 0);
    hz2_pulse();
    chk("blink_m_on", blink_min, 1);
    repeat (59) press(1'b0, 1'b1);
    chk("min_59", minute, 59);
    press(1'b0, 1'b1);
    chk("min_wrap", minute, 0);
    chk("min_wrap_hour", hour, 23);
    repeat (59) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    chk("mode_run", mode, 0);
    chk("exit_sec_clear", second, 0);
    chk("exit_blink_m", blink_min, 0);

    // Full rollover
    repeat (59) hz1_pulse();
    chk("pre_hour", hour, 23);
    chk("pre_min", minute, 59);
    chk("pre_sec", second, 59);
    hz1_pulse();
    chk("roll_hour", hour, 0);
    chk("roll_min", minute, 0);
    chk("roll_sec", second, 0);

    // Bounce of DEB-1 samples produces no event
    @(negedge clk) key_mode = 1'b1;
    wait_neg(3);
    repeat (DEB - 1) khz_pulse();
    key_mode = 1'b0;
    wait_neg(3);
    repeat (DEB + 1) khz_pulse();
    wait_neg(2);
    chk("bounce_mode", mode, 0);

    // Simultaneous mode and inc: mode wins
    press(1'b1, 1'b0);
    chk("sim_pre_mode", mode, 1);
    press(1'b1, 1'b1);
    chk("sim_mode", mode, 2);
    chk("sim_hour", hour, 0);
    chk("sim_min", minute, 0);

    // Asynchronous reset mid-debounce in SET_MIN
    press(1'b0, 1'b1);
    chk("pre_rst_min", minute, 1);
    chk("pre_rst_mode", mode, 2);
    @(negedge clk) key_inc = 1'b1;
    wait_neg(3);
    repeat (2) khz_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_min", minute, 0);
    chk("arst_hour", hour, 0);
    chk("arst_sec", second, 0);
    chk("arst_scan", scan_sel, 0);
    chk("arst_blink_m", blink_min, 0);
    key_inc = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
